// File: rtl/halfbridge_pwm_mc.sv
// Multi-leg half-bridge PWM: shared carrier, interleaved phases, double-buffered duty and a
// per-leg dead-time FSM. Optional fault latch under `HB_FAULT_EN.

module halfbridge_pwm_leg #(
  parameter int DT  = 8,
  parameter int DTW = 8
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic hold_i,
  input  logic raw_i,
  output logic hs_o,
  output logic ls_o
);
  localparam logic [1:0] LOW_ON     = 2'd0;
  localparam logic [1:0] DT_TO_HIGH = 2'd1;
  localparam logic [1:0] HIGH_ON    = 2'd2;
  localparam logic [1:0] DT_TO_LOW  = 2'd3;

  // dtc counts down to 0 inclusive: a reload of DT-1 gives a DT-cycle gap, while the
  // reset/fault hold value of DT adds one extra cycle for a safe start.
  localparam logic [DTW-1:0] DT_HOLD = DTW'(DT);
  localparam logic [DTW-1:0] DT_ENT  = DTW'(DT > 0 ? DT - 1 : 0);

  logic [1:0]     state_q, state_d;
  logic [DTW-1:0] dtc_q, dtc_d;
  logic           hs_q, ls_q;

  always_comb begin
    state_d = state_q;
    dtc_d   = dtc_q;
    if (hold_i) begin
      state_d = DT_TO_LOW;
      dtc_d   = DT_HOLD;
    end else begin
      case (state_q)
        LOW_ON: if (raw_i) begin
          state_d = DT_TO_HIGH;
          dtc_d   = DT_ENT;
        end
        DT_TO_HIGH: begin
          if (!raw_i) begin
            state_d = DT_TO_LOW;
            dtc_d   = DT_ENT;
          end else if (dtc_q == '0) state_d = HIGH_ON;
          else dtc_d = dtc_q - 1'b1;
        end
        HIGH_ON: if (!raw_i) begin
          state_d = DT_TO_LOW;
          dtc_d   = DT_ENT;
        end
        default: begin
          if (raw_i) begin
            state_d = DT_TO_HIGH;
            dtc_d   = DT_ENT;
          end else if (dtc_q == '0) state_d = LOW_ON;
          else dtc_d = dtc_q - 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= DT_TO_LOW;
      dtc_q   <= DT_HOLD;
      hs_q    <= 1'b0;
      ls_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      dtc_q   <= dtc_d;
      hs_q    <= (state_d == HIGH_ON);
      ls_q    <= (state_d == LOW_ON);
    end
  end

  assign hs_o = hs_q;
  assign ls_o = ls_q;
endmodule

module halfbridge_pwm_mc #(
  parameter int CW     = 10,
  parameter int PERIOD = 1000,
  parameter int NCH    = 2,
  parameter int DT     = 8,
  parameter int DTW    = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              ce_i,
  input  logic [NCH*CW-1:0] d_in_i,
  input  logic              d_load_i,
`ifdef HB_FAULT_EN
  input  logic              fault_i,
  input  logic              fault_clr_i,
  output logic              fault_latched_o,
`endif
  output logic [NCH-1:0]    hs_o,
  output logic [NCH-1:0]    ls_o,
  output logic              period_tick_o
);
  localparam int STEP = PERIOD / NCH;

  logic [CW-1:0]           cnt_q;
  logic                    tick_q, wrap, hold;
  logic [NCH-1:0][CW-1:0]  d_in_w, shadow_q, active_q;
  logic [NCH-1:0]          raw_d, raw_q;

  assign d_in_w = d_in_i;
  assign wrap   = ce_i && (cnt_q == CW'(PERIOD - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      tick_q <= wrap;
      if (ce_i) cnt_q <= wrap ? '0 : cnt_q + 1'b1;
    end
  end

  // Active duty only moves on the wrap; a strobe landing on the wrap bypasses the shadow.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      shadow_q <= '0;
      active_q <= '0;
    end else begin
      if (d_load_i) shadow_q <= d_in_w;
      if (wrap) active_q <= d_load_i ? d_in_w : shadow_q;
    end
  end

`ifdef HB_FAULT_EN
  logic fault_q;
  always_ff @(posedge clk_i) begin
    if (rst_i) fault_q <= 1'b0;
    else if (fault_i) fault_q <= 1'b1;
    else if (fault_clr_i) fault_q <= 1'b0;
  end
  assign hold            = fault_i | fault_q;
  assign fault_latched_o = fault_q;
`else
  assign hold = 1'b0;
`endif

  for (genvar k = 0; k < NCH; k++) begin : g_leg
    localparam logic [CW:0] OFS = (CW + 1)'(k * STEP);
    logic [CW:0] sum, phase;
    assign sum   = {1'b0, cnt_q} + OFS;
    assign phase = (sum >= (CW + 1)'(PERIOD)) ? sum - (CW + 1)'(PERIOD) : sum;
    // phase never reaches PERIOD, so any duty at or above PERIOD already reads as fully on
    assign raw_d[k] = phase < {1'b0, active_q[k]};

    halfbridge_pwm_leg #(.DT(DT), .DTW(DTW)) u_leg (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .hold_i (hold),
      .raw_i  (raw_q[k]),
      .hs_o   (hs_o[k]),
      .ls_o   (ls_o[k])
    );
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) raw_q <= '0;
    else raw_q <= raw_d;
  end

  assign period_tick_o = tick_q;
endmodule

// File: tb/tb_halfbridge_pwm_mc.sv
// Bench for halfbridge_pwm_mc: PERIOD=100, NCH=2, DT=4; duty table plus hand-written
// shadow, bypass, ce-gating, reset and (with HB_FAULT_EN) fault sequences.

module tb_halfbridge_pwm_mc;
  localparam int CW = 10, PERIOD = 100, NCH = 2, DT = 4, DTW = 8;
  localparam int DC = -99;

  logic              clk = 1'b0;
  logic              rst, ce, d_load;
  logic [NCH*CW-1:0] d_in;
  logic [NCH-1:0]    hs, ls;
  logic              tick;
`ifdef HB_FAULT_EN
  logic              fault, fault_clr, fault_latched;
`endif

  always #5 clk = ~clk;

  halfbridge_pwm_mc #(.CW(CW), .PERIOD(PERIOD), .NCH(NCH), .DT(DT), .DTW(DTW)) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .ce_i            (ce),
    .d_in_i          (d_in),
    .d_load_i        (d_load),
`ifdef HB_FAULT_EN
    .fault_i         (fault),
    .fault_clr_i     (fault_clr),
    .fault_latched_o (fault_latched),
`endif
    .hs_o            (hs),
    .ls_o            (ls),
    .period_tick_o   (tick)
  );

  typedef struct {
    int hs0, ls0, hs1, ls1, ovl, r0, r1;
  } meas_t;
  typedef struct {
    int    d0, d1;
    meas_t exp;
  } vec_t;

  int    n_chk = 0, n_pass = 0;
  meas_t sb[$];
  vec_t  vecs[4];

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic cmp(input string tag, input meas_t m, input meas_t e);
    if (e.hs0 != DC) check({tag, "_hs0"}, m.hs0, e.hs0);
    if (e.ls0 != DC) check({tag, "_ls0"}, m.ls0, e.ls0);
    if (e.hs1 != DC) check({tag, "_hs1"}, m.hs1, e.hs1);
    if (e.ls1 != DC) check({tag, "_ls1"}, m.ls1, e.ls1);
    if (e.ovl != DC) check({tag, "_overlap"}, m.ovl, e.ovl);
    if (e.r0  != DC) check({tag, "_rise0"}, m.r0, e.r0);
    if (e.r1  != DC) check({tag, "_rise1"}, m.r1, e.r1);
  endtask

  task automatic wait_tick(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!tick && n < 400);
    if (!tick) begin
      n_chk++;
      $display("FAIL tick_timeout: no period_tick within %0d cycles", n);
    end
  endtask

  // Samples one carrier period of outputs, optionally strobing a duty load at offset ld_at.
  task automatic measure(input int ld_at, input int ld_val, output meas_t m);
    logic [NCH-1:0] prev;
    m = '{hs0: 0, ls0: 0, hs1: 0, ls1: 0, ovl: 0, r0: -1, r1: -1};
    prev = hs;
    for (int i = 0; i < PERIOD; i++) begin
      if (i == ld_at) begin
        d_in   = {NCH{CW'(ld_val)}};
        d_load = 1'b1;
      end else d_load = 1'b0;
      m.hs0 += int'(hs[0]);
      m.ls0 += int'(ls[0]);
      m.hs1 += int'(hs[1]);
      m.ls1 += int'(ls[1]);
      if (|(hs & ls)) m.ovl++;
      if (hs[0] && !prev[0] && m.r0 < 0) m.r0 = i;
      if (hs[1] && !prev[1] && m.r1 < 0) m.r1 = i;
      prev = hs;
      @(negedge clk);
    end
    d_load = 1'b0;
  endtask

  task automatic load_now(input int d0, input int d1);
    d_in   = {CW'(d1), CW'(d0)};
    d_load = 1'b1;
    @(negedge clk);
    d_load = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int    n, bad;
    meas_t m, e;

    vecs[0] = '{d0: 50,  d1: 50, exp: '{hs0: 46,  ls0: 46, hs1: 46, ls1: 46,  ovl: 0, r0: 6,  r1: 56}};
    vecs[1] = '{d0: 20,  d1: 80, exp: '{hs0: 16,  ls0: 76, hs1: 76, ls1: 16,  ovl: 0, r0: 6,  r1: 56}};
    vecs[2] = '{d0: 150, d1: 0,  exp: '{hs0: 100, ls0: 0,  hs1: 0,  ls1: 100, ovl: 0, r0: -1, r1: -1}};
    vecs[3] = '{d0: 5,   d1: 3,  exp: '{hs0: 1,   ls0: 91, hs1: 0,  ls1: 93,  ovl: 0, r0: 6,  r1: -1}};

    rst = 1'b1; ce = 1'b1; d_load = 1'b0; d_in = '0;
`ifdef HB_FAULT_EN
    fault = 1'b0; fault_clr = 1'b0;
`endif
    repeat (3) begin
      @(negedge clk);
      check("rst_hs", int'(hs), 0);
      check("rst_ls", int'(ls), 0);
      check("rst_tick", int'(tick), 0);
    end
    rst = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      check($sformatf("release_ls_e%0d", k), int'(ls), (k == 5) ? 3 : 0);
      check($sformatf("release_hs_e%0d", k), int'(hs), 0);
    end
    wait_tick(n);
    check("tick_first", n + 5, 100);
    wait_tick(n);
    check("tick_period", n, 100);

    foreach (vecs[v]) begin
      load_now(vecs[v].d0, vecs[v].d1);
      sb.push_back(vecs[v].exp);
      wait_tick(n);
      wait_tick(n);
      measure(-1, 0, m);
      e = sb.pop_front();
      cmp($sformatf("vec%0d", v), m, e);
    end

    // Shadow: strobe 30 mid-period keeps the running period, applies on the next one.
    load_now(50, 50);
    wait_tick(n);
    wait_tick(n);
    sb.push_back('{hs0: 46, ls0: 46, hs1: DC, ls1: DC, ovl: 0, r0: 6, r1: DC});
    measure(20, 30, m);
    e = sb.pop_front();
    cmp("shadow_cur", m, e);
    sb.push_back('{hs0: 26, ls0: 66, hs1: DC, ls1: DC, ovl: 0, r0: 6, r1: DC});
    measure(-1, 0, m);
    e = sb.pop_front();
    cmp("shadow_next", m, e);
    // Bypass: strobe 70 exactly on the wrap cycle.
    sb.push_back('{hs0: 26, ls0: DC, hs1: DC, ls1: DC, ovl: 0, r0: DC, r1: DC});
    sb.push_back('{hs0: 66, ls0: 26, hs1: DC, ls1: DC, ovl: 0, r0: 6, r1: DC});
    measure(99, 70, m);
    e = sb.pop_front();
    cmp("bypass_cur", m, e);
    measure(-1, 0, m);
    e = sb.pop_front();
    cmp("bypass_next", m, e);

    // ce low for 20 cycles while leg 0 is HIGH_ON.
    load_now(50, 50);
    wait_tick(n);
    wait_tick(n);
    repeat (20) @(negedge clk);
    ce  = 1'b0;
    bad = 0;
    for (int j = 1; j <= 20; j++) begin
      @(negedge clk);
      if (hs !== 2'b01 || ls !== 2'b10) bad++;
      if (j == 20) ce = 1'b1;
    end
    check("ce_hold_bad_cycles", bad, 0);
    wait_tick(n);
    check("ce_tick_stretch", n, 80);

    // ce low from inside DT_TO_HIGH: the dead time still expires on clk.
    @(negedge clk);
    ce = 1'b0;
    for (int j = 2; j <= 21; j++) begin
      @(negedge clk);
      if (j == 5) begin
        check("ce_dth_gap_hs0", int'(hs[0]), 0);
        check("ce_dth_gap_ls0", int'(ls[0]), 0);
      end
      if (j == 6) check("ce_dth_rise_hs0", int'(hs[0]), 1);
      if (j == 21) ce = 1'b1;
    end
    wait_tick(n);
    check("ce_dth_tick", n, 99);

    // Reset asserted mid-operation with leg 0 HIGH_ON.
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_hs", int'(hs), 0);
    check("midrst_ls", int'(ls), 0);
    check("midrst_tick", int'(tick), 0);
    rst = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      check($sformatf("midrst_ls_e%0d", k), int'(ls), (k == 5) ? 3 : 0);
    end
    wait_tick(n);
    check("midrst_tick_restart", n, 95);

`ifdef HB_FAULT_EN
    repeat (10) @(negedge clk);
    fault = 1'b1;
    @(negedge clk);
    fault = 1'b0;
    check("fault_hs", int'(hs), 0);
    check("fault_ls", int'(ls), 0);
    check("fault_latched", int'(fault_latched), 1);
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (hs !== 2'b00 || ls !== 2'b00 || fault_latched !== 1'b1) bad++;
    end
    check("fault_hold_bad_cycles", bad, 0);
    fault = 1'b1;
    fault_clr = 1'b1;
    @(negedge clk);
    fault = 1'b0;
    check("fault_prio_over_clr", int'(fault_latched), 1);
    @(negedge clk);
    fault_clr = 1'b0;
    check("fault_cleared", int'(fault_latched), 0);
    check("fault_clr_ls0", int'(ls), 0);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      check($sformatf("fault_clr_ls_e%0d", k), int'(ls), (k == 5) ? 3 : 0);
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/halfbridge_pwm_mc.md
# halfbridge_pwm_mc

Multi-channel, parametrised half-bridge PWM generator with programmable dead time, interleaved carrier phases and glitch-free double-buffered duty update. It sits between the control loop, which supplies duty words, and the gate-driver pins. It drives one complementary high-side/low-side pair per leg and guarantees the two outputs of a leg are never high together.

## Interface
- CW, 10, counter and duty width in bits
- PERIOD, 1000, carrier period in counter ticks; counter runs 0..PERIOD-1; PERIOD ≤ 2^CW
- NCH, 2, number of half-bridge legs
- DT, 8, dead time in clk cycles; 0 allowed
- DTW, 8, dead-time counter width; DT < 2^DTW
- clk  in  1  system clock; one clock domain
- rst  in  1  synchronous reset, active-high
- ce  in  1  counter advance enable; the carrier counter steps only on cycles with ce=1
- d_in  in  NCH*CW  packed duty words; channel k occupies bits [k*CW +: CW]
- d_load  in  1  one-cycle strobe; captures d_in into the shadow registers
- hs  out  NCH  high-side gate, one bit per leg
- ls  out  NCH  low-side gate, one bit per leg
- period_tick  out  1  one-clk pulse when the carrier wraps

## Operation
- Carrier: cnt increments on ce. It wraps PERIOD-1→0. period_tick=1 in the clk cycle after the wrap, for one cycle only.
- Duty buffering:
  - d_load writes shadow[k]=d_in[k] for all channels.
  - On the wrap cycle (cnt==PERIOD-1 && ce), active[k] loads shadow[k].
  - If d_load coincides with the wrap, active[k] takes d_in[k] directly, bypassing the shadow.
  - Active never changes mid-period.
- Saturation: active duty > PERIOD is treated as PERIOD (leg fully on). Duty 0 means the leg is fully off.
- Interleave: channel k compares phase_k = (cnt + k*(PERIOD/NCH)) mod PERIOD, using integer division.
- Raw demand: raw_q[k] is registered as phase_k < active[k].
- Per-leg dead-time FSM, with states LOW_ON, DT_TO_HIGH, HIGH_ON, DT_TO_LOW:
  - LOW_ON: ls=1, hs=0. If raw_q=1, go to DT_TO_HIGH and load dtc=DT.
  - DT_TO_HIGH: hs=0, ls=0, dtc decrements each clk. When dtc==0 and raw_q=1, go to HIGH_ON. If raw_q=0 first, go to DT_TO_LOW and reload dtc=DT.
  - HIGH_ON: hs=1, ls=0. If raw_q=0, go to DT_TO_LOW and load dtc=DT.
  - DT_TO_LOW: both 0. When dtc==0 and raw_q=0, go to LOW_ON. If raw_q=1 first, go to DT_TO_HIGH and reload dtc=DT.
  - DT=0: the dead-time states last exactly one clk cycle with both outputs low.
- Dead-time counting uses clk, not ce. With ce=0 the carrier freezes but pending dead times still expire.
- hs and ls are registered outputs decoded from the state. No combinational path from inputs to outputs.

## Timing
- Reset values:
  - cnt=0, shadow=0, active=0, raw_q=0, period_tick=0.
  - All legs in DT_TO_LOW with dtc=DT; hs=0, ls=0.
  - ls goes high DT+1 clk cycles after rst deasserts, which gives a safe start.
- rst asserted mid-operation: on the next edge all outputs are 0 and all state is as above, regardless of FSM state.
- Latency: hs=1 occurs DT+1 cycles after the first cycle raw_q=1. If raw_q rises at cycle t, ls=0 at t+1 and hs=1 at t+1+DT.
- Pulse widths with ce=1 every cycle and 0 < duty < PERIOD:
  - hs high = duty−DT cycles, clamped at 0.
  - ls high = PERIOD−duty−DT cycles, clamped at 0.
  - A raw pulse of DT cycles or fewer produces no hs pulse.
- Duty written via d_load takes effect in the period starting after the next wrap. Worst-case latency is PERIOD ce-ticks plus 1 clk.

## Configuration
- HB_FAULT_EN defined adds the following:
  - Inputs fault (1 bit) and fault_clr (1 bit), and output fault_latched (1 bit, reset 0).
  - When fault=1 is sampled, fault_latched=1 and on the next edge every leg is forced to DT_TO_LOW with hs=ls=0. Legs stay held there with dtc=DT.
  - fault_clr=1 with fault=0 clears the latch. The legs then resume per the FSM, so ls returns after DT+1 cycles.
  - Fault has priority over fault_clr.
- HB_FAULT_EN undefined: these ports and the logic do not exist, and the behaviour is exactly as in Operation.

## Test plan
Common settings: PERIOD=100, NCH=2, DT=4, CW=10, ce=1 unless noted.
- Reset: hold rst 3 cycles → hs=ls=0 throughout. After release, ls=1 on the 5th edge; period_tick pulses every 100 cycles.
- Duty 50 on both channels, loaded before a wrap:
  - Each leg: hs high 46 cycles, ls high 46 cycles, 4-cycle gaps with both low.
  - ch1 hs rising edge lags ch0 by 50 cycles.
  - hs&ls never equals 1.
- Shadow update: d_in=30 strobed at cnt=20 → current period keeps 50-duty timing; next period hs high 26 cycles.
- Boundaries:
  - Duty 150 → hs stays 1 and ls stays 0 after the first transition.
  - Duty 0 → hs never asserts.
  - Duty 3 (≤ DT) → no hs pulse and ls low 7 cycles per period.
- ce gating: ce=0 for 20 cycles during HIGH_ON → outputs hold. ce=0 asserted during DT_TO_HIGH → hs still rises after DT.
- With HB_FAULT_EN: fault pulsed 1 cycle at cnt=10 → hs=ls=0 next edge and held. fault_clr → ls=1 after 5 cycles.
